prog_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the pipelined CPU core.
- Receives a byte stream from a host link and assembles 16-bit instruction words.
- Writes the words into instruction memory (8-bit word address), verifies a checksum, then releases the core with a one-cycle start pulse and holds enable high.
- Holds the core disabled during loading and after a failed load.

---
 rtl/prog_loader.sv | 202 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader
// Boot-time program loader in front of the CPU core. It takes a framed byte
// stream from the host link, assembles 16-bit instruction words, writes them
// into instruction memory, verifies an 8-bit additive checksum and then
// releases the core with a one-cycle start pulse while holding enable high.
// The core stays disabled while a frame is loading and after a failed load.
//
// Frame: count byte C (C=0 means 256 words), 2N data bytes high byte first,
// then the modulo-256 sum of the data bytes.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-low reset
//   in_data       host byte
//   in_valid      in_data valid
//   in_ready      loader can accept a byte
//   load_req      one-cycle request: abort, stop the core and reload
//   im_we         instruction-memory write strobe
//   im_addr       instruction-memory word address
//   im_data       instruction word to write
//   cpu_start     one-cycle start pulse to the core
//   cpu_enable    core enable
//   busy          a frame is in progress
//   err           last load failed (checksum or timeout)
//   words_loaded  words written in the current or last frame
module prog_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned TO_W      = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_req,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [15:0] im_data,
  output logic        cpu_start,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err,
  output logic [8:0]  words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_START = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  // Running modulo-256 checksum update.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  // A frame state is one where a data or checksum byte is awaited.
  function automatic logic is_frame_state(input logic [2:0] s);
    return (s == S_HI) || (s == S_LO) || (s == S_CSUM);
  endfunction

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [8:0]      n_words;
  logic [7:0]      hi_byte;
  logic [7:0]      csum;
  logic [TO_W-1:0] to_cnt;

  logic accept;
  logic in_frame;
  logic timed_out;
  logic take;
  logic last_word;

  assign accept    = in_valid && in_ready;
  assign in_frame  = is_frame_state(state);
  assign timed_out = in_frame && (to_cnt == TO_LIMIT);
  // Inside a frame, an abort request or an expired timeout discards the byte.
  assign take      = accept && !load_req && !timed_out;
  assign last_word = (words_loaded + 9'd1) == n_words;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // load_req is ignored here; only the count byte moves us on.
        if (accept) state_nxt = S_HI;
        else        state_nxt = S_IDLE;
      end
      S_HI: begin
        if (load_req)       state_nxt = S_IDLE;
        else if (timed_out) state_nxt = S_ERR;
        else if (accept)    state_nxt = S_LO;
        else                state_nxt = S_HI;
      end
      S_LO: begin
        if (load_req)       state_nxt = S_IDLE;
        else if (timed_out) state_nxt = S_ERR;
        else if (accept)    state_nxt = last_word ? S_CSUM : S_HI;
        else                state_nxt = S_LO;
      end
      S_CSUM: begin
        if (load_req)       state_nxt = S_IDLE;
        else if (timed_out) state_nxt = S_ERR;
        else if (accept)    state_nxt = (in_data == csum) ? S_START : S_ERR;
        else                state_nxt = S_CSUM;
      end
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (load_req) state_nxt = S_IDLE;
        else          state_nxt = S_RUN;
      end
      S_ERR: begin
        if (load_req) state_nxt = S_IDLE;
        else          state_nxt = S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and status outputs, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      cpu_enable <= 1'b0;
      cpu_start  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready   <= (state_nxt == S_IDLE) || is_frame_state(state_nxt);
      busy       <= is_frame_state(state_nxt);
      cpu_enable <= (state_nxt == S_START) || (state_nxt == S_RUN);
      cpu_start  <= (state_nxt == S_START);
      err        <= (state_nxt == S_ERR);
    end
  end

  // Inter-byte idle counter; runs only while staying inside a frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (in_frame && is_frame_state(state_nxt) && !accept) begin
      to_cnt <= to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      to_cnt <= '0;
    end
  end

  // Frame datapath: word count, checksum, byte assembly and memory write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_words      <= 9'd0;
      hi_byte      <= 8'd0;
      csum         <= 8'd0;
      words_loaded <= 9'd0;
      im_we        <= 1'b0;
      im_addr      <= 8'd0;
      im_data      <= 16'd0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            n_words      <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            csum         <= 8'd0;
            words_loaded <= 9'd0;
          end
        end
        S_HI: begin
          if (take) begin
            hi_byte <= in_data;
            csum    <= csum_add(csum, in_data);
          end
        end
        S_LO: begin
          // The write lands one cycle after the low byte, overlapping the
          // next word's high byte. words_loaded doubles as the word index.
          if (take) begin
            csum         <= csum_add(csum, in_data);
            im_we        <= 1'b1;
            im_addr      <= BASE_ADDR + words_loaded[7:0];
            im_data      <= {hi_byte, in_data};
            words_loaded <= words_loaded + 9'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;

  typedef struct packed {
    logic        is_start;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        load_req;
  logic        sel;

  logic        in_valid0, load_req0, in_ready0, im_we0, cpu_start0, cpu_enable0, busy0, err0;
  logic [7:0]  im_addr0;
  logic [15:0] im_data0;
  logic [8:0]  words_loaded0;
  logic        in_valid1, load_req1, in_ready1, im_we1, cpu_start1, cpu_enable1, busy1, err1;
  logic [7:0]  im_addr1;
  logic [15:0] im_data1;
  logic [8:0]  words_loaded1;
  logic        rdy;

  assign in_valid0 = in_valid & ~sel;
  assign load_req0 = load_req & ~sel;
  assign in_valid1 = in_valid & sel;
  assign load_req1 = load_req & sel;
  assign rdy       = sel ? in_ready1 : in_ready0;

  prog_loader #(.BASE_ADDR(8'h00), .TIMEOUT(1024), .TO_W(11)) dut0 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid0),
    .in_ready(in_ready0), .load_req(load_req0), .im_we(im_we0), .im_addr(im_addr0),
    .im_data(im_data0), .cpu_start(cpu_start0), .cpu_enable(cpu_enable0),
    .busy(busy0), .err(err0), .words_loaded(words_loaded0)
  );

  prog_loader #(.BASE_ADDR(8'hF0), .TIMEOUT(1024), .TO_W(11)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid1),
    .in_ready(in_ready1), .load_req(load_req1), .im_we(im_we1), .im_addr(im_addr1),
    .im_data(im_data1), .cpu_start(cpu_start1), .cpu_enable(cpu_enable1),
    .busy(busy1), .err(err1), .words_loaded(words_loaded1)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_write(input bit which, input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.is_start = 1'b0; e.addr = a; e.data = d;
    if (which) q1.push_back(e);
    else       q0.push_back(e);
  endtask

  task automatic exp_start(input bit which);
    exp_t e;
    e.is_start = 1'b1; e.addr = 8'd0; e.data = 16'd0;
    if (which) q1.push_back(e);
    else       q0.push_back(e);
  endtask

  // Scoreboard monitor: pops one expected event per write strobe or start pulse.
  task automatic mon_step(input bit which, input logic we, input logic st,
                          input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    int   sz;
    if (we || st) begin
      sz = which ? q1.size() : q0.size();
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL mon%0d_unexpected we=%0b start=%0b addr=%0h data=%0h expected no event",
                 which, we, st, a, d);
      end else begin
        if (which) e = q1.pop_front();
        else       e = q0.pop_front();
        check($sformatf("mon%0d_kind", which), {31'd0, st}, {31'd0, e.is_start});
        if (!e.is_start) begin
          check($sformatf("mon%0d_addr", which), {24'd0, a}, {24'd0, e.addr});
          check($sformatf("mon%0d_data", which), {16'd0, d}, {16'd0, e.data});
        end
      end
    end
  endtask

  always @(negedge clock) mon_step(1'b0, im_we0, cpu_start0, im_addr0, im_data0);
  always @(negedge clock) mon_step(1'b1, im_we1, cpu_start1, im_addr1, im_data1);

  // Present a byte and wait (bounded) until it is accepted; returns 1 after the edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!rdy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_wait byte=%0h in_ready=0 expected 1", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clock);
    #1;
    load_req = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clock);
    #1;
    check(name, q0.size() + q1.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] sum;
    logic [7:0] idx;
    reset = 1'b0; in_data = 8'd0; in_valid = 1'b0; load_req = 1'b0; sel = 1'b0;
    #12;
    // Reset values while reset is held.
    check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    check("rst_im_we", {31'd0, im_we0}, 32'd0);
    check("rst_cpu_enable", {31'd0, cpu_enable0}, 32'd0);
    check("rst_cpu_start", {31'd0, cpu_start0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_err", {31'd0, err0}, 32'd0);
    check("rst_words", {23'd0, words_loaded0}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Good two-word frame; 12+34+AB+CD = 0x1BE so the checksum byte is BE.
    exp_write(1'b0, 8'h00, 16'h1234);
    exp_write(1'b0, 8'h01, 16'hABCD);
    exp_start(1'b0);
    send(8'h02);
    check("t1_busy", {31'd0, busy0}, 32'd1);
    send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    check("t1_we_latency", {31'd0, im_we0}, 32'd1);
    check("t1_we_addr", {24'd0, im_addr0}, 32'h01);
    send(8'hBE);
    in_valid = 1'b0;
    check("t1_start", {31'd0, cpu_start0}, 32'd1);
    check("t1_enable", {31'd0, cpu_enable0}, 32'd1);
    check("t1_busy_end", {31'd0, busy0}, 32'd0);
    check("t1_words", {23'd0, words_loaded0}, 32'd2);
    check("t1_err", {31'd0, err0}, 32'd0);
    idle(1);
    check("t1_start_pulse", {31'd0, cpu_start0}, 32'd0);
    check("t1_run_enable", {31'd0, cpu_enable0}, 32'd1);
    check("t1_run_ready", {31'd0, in_ready0}, 32'd0);
    // Reload request from RUN.
    pulse_load();
    check("run_load_enable", {31'd0, cpu_enable0}, 32'd0);
    check("run_load_ready", {31'd0, in_ready0}, 32'd1);
    drain("t1_drain");

    // Same frame with a wrong checksum.
    exp_write(1'b0, 8'h00, 16'h1234);
    exp_write(1'b0, 8'h01, 16'hABCD);
    send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h8F);
    in_valid = 1'b0;
    check("t2_err", {31'd0, err0}, 32'd1);
    check("t2_enable", {31'd0, cpu_enable0}, 32'd0);
    check("t2_ready", {31'd0, in_ready0}, 32'd0);
    idle(2);
    check("t2_err_hold", {31'd0, err0}, 32'd1);
    pulse_load();
    check("t2_err_clear", {31'd0, err0}, 32'd0);
    check("t2_ready_back", {31'd0, in_ready0}, 32'd1);
    drain("t2_drain");

    // 256-word frame: 512 bytes of 01 sum to 0x200, checksum 00.
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      exp_write(1'b0, idx, 16'h0101);
    end
    exp_start(1'b0);
    send(8'h00);
    for (int i = 0; i < 512; i++) send(8'h01);
    send(8'h00);
    in_valid = 1'b0;
    check("t3_words", {23'd0, words_loaded0}, 32'd256);
    check("t3_start", {31'd0, cpu_start0}, 32'd1);
    idle(1);
    pulse_load();
    drain("t3_drain");

    // load_req together with a byte in LO: byte discarded, back to IDLE.
    send(8'h02); send(8'h12);
    in_data = 8'h34; in_valid = 1'b1; load_req = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0; load_req = 1'b0;
    check("t6_no_write", {31'd0, im_we0}, 32'd0);
    check("t6_busy", {31'd0, busy0}, 32'd0);
    check("t6_ready", {31'd0, in_ready0}, 32'd1);
    // A fresh frame after the abort: AA+BB = 0x165.
    exp_write(1'b0, 8'h00, 16'hAABB);
    exp_start(1'b0);
    send(8'h01); send(8'hAA); send(8'hBB); send(8'h65);
    in_valid = 1'b0;
    check("t6_words", {23'd0, words_loaded0}, 32'd1);
    idle(1);
    pulse_load();
    drain("t6_drain");

    // Timeout: TIMEOUT idle cycles reach the limit, the next edge enters ERR.
    send(8'h01); send(8'h55);
    idle(1024);
    check("t5_boundary_err", {31'd0, err0}, 32'd0);
    idle(1);
    check("t5_err", {31'd0, err0}, 32'd1);
    check("t5_busy", {31'd0, busy0}, 32'd0);
    drain("t5_drain");
    pulse_load();
    check("t5_err_clear", {31'd0, err0}, 32'd0);
    // Gaps of TIMEOUT-1 cycles still succeed: 55+66 = BB.
    exp_write(1'b0, 8'h00, 16'h5566);
    exp_start(1'b0);
    send(8'h01); idle(1023);
    send(8'h55); idle(1023);
    send(8'h66); idle(1023);
    send(8'hBB);
    in_valid = 1'b0;
    check("t5_gap_start", {31'd0, cpu_start0}, 32'd1);
    check("t5_gap_err", {31'd0, err0}, 32'd0);
    idle(1);
    pulse_load();
    drain("t5_gap_drain");

    // Address wrap on the BASE_ADDR=F0 instance with 32 words.
    sel = 1'b1;
    sum = 8'd0;
    for (int i = 0; i < 32; i++) begin
      idx = 8'(i);
      exp_write(1'b1, 8'hF0 + idx, {idx, 8'h80 + idx});
      sum = sum + idx + (8'h80 + idx);
    end
    exp_start(1'b1);
    send(8'h20);
    for (int i = 0; i < 32; i++) begin
      idx = 8'(i);
      send(idx);
      send(8'h80 + idx);
    end
    send(sum);
    in_valid = 1'b0;
    check("t4_words", {23'd0, words_loaded1}, 32'd32);
    check("t4_start", {31'd0, cpu_start1}, 32'd1);
    idle(1);
    pulse_load();
    drain("t4_drain");
    sel = 1'b0;

    // Asynchronous reset in the middle of a frame, while a write is showing.
    send(8'h02); send(8'h12); send(8'h34);
    in_valid = 1'b0;
    check("t7_we_before", {31'd0, im_we0}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t7_we", {31'd0, im_we0}, 32'd0);
    check("t7_ready", {31'd0, in_ready0}, 32'd1);
    check("t7_busy", {31'd0, busy0}, 32'd0);
    check("t7_words", {23'd0, words_loaded0}, 32'd0);
    check("t7_addr", {24'd0, im_addr0}, 32'd0);
    check("t7_data", {16'd0, im_data0}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drain("t7_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
